round_block_mc: RTL

- Parametrised, multi-channel successor of the single-pair round block in the sparse polynomial multiplier datapath.
- Buffers the most recent DEPTH words of the dense (normal) operand in a sliding window.
- For every accepted word, emits NUM_CH (left,right) word pairs, each tapped at a per-channel runtime offset plus latency bit. Taps that fall outside the polynomial are zero-guarded.
- Sits between the normal-word streamer and the per-round shift/XOR accumulators, with valid/ready handshakes on both sides.

---
 rtl/round_pkg.sv | 25 ++
 rtl/round_tap.sv | 48 ++++
 rtl/round_block_mc.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/round_pkg.sv
// Shared types and helpers for the multi-channel round block.
package round_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_EMIT
  } state_e;

  localparam int WORD_WIDTH_DEF = 32;
  localparam int DEPTH_DEF      = 20;
  localparam int NUM_CH_DEF     = 2;
  localparam int WORD_COUNT_DEF = 553;
  localparam int OFF_W_DEF      = 6;
  localparam int CNT_W_DEF      = 10;

  function automatic int tap_idx(
    input int n,
    input int d,
    input int l
  );
    return n - 1 - d - l;
  endfunction

endpackage

// File: rtl/round_tap.sv
// One tap channel: index arithmetic, bounds guard and window mux.
module round_tap
  import round_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int WORD_COUNT = WORD_COUNT_DEF,
  parameter int OFF_W      = OFF_W_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic [CNT_W-1:0]            n,
  input  logic [OFF_W-1:0]            d,
  input  logic                        l,
  input  logic [DEPTH*WORD_WIDTH-1:0] win,
  output logic [WORD_WIDTH-1:0]       left,
  output logic [WORD_WIDTH-1:0]       right
);

  logic signed [CNT_W:0] j_l;
  logic signed [CNT_W:0] j_r;

  function automatic logic [WORD_WIDTH-1:0] pick(
    input logic signed [CNT_W:0]      j,
    input logic [CNT_W-1:0]           cnt,
    input logic [DEPTH*WORD_WIDTH-1:0] w
  );
    int ji;
    int pos;
    logic [WORD_WIDTH-1:0] r;
    ji  = int'(j);
    pos = int'(cnt) - 1 - ji;
    r   = '0;
    if (ji >= 0 && ji < WORD_COUNT && pos < DEPTH) begin
      for (int p = 0; p < DEPTH; p++) begin
        if (p == pos) r = w[p*WORD_WIDTH +: WORD_WIDTH];
      end
    end
    return r;
  endfunction

  always_comb begin
    j_l   = (CNT_W+1)'(tap_idx(int'(n), int'(d), int'(l)));
    j_r   = (CNT_W+1)'(tap_idx(int'(n), int'(d), int'(l)) - 1);
    left  = pick(j_l, n, win);
    right = pick(j_r, n, win);
  end

endmodule

// File: rtl/round_block_mc.sv
// Multi-channel round block: sliding window of normal words, NUM_CH taps.
// Optional ROUND_BLOCK_MC_CFG_CHECK_EN builds the sticky cfg_err check.
module round_block_mc
  import round_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int NUM_CH     = NUM_CH_DEF,
  parameter int WORD_COUNT = WORD_COUNT_DEF,
  parameter int OFF_W      = OFF_W_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [WORD_WIDTH-1:0]        in_word,
  input  logic                         in_valid,
  input  logic                         in_only_add,
  output logic                         in_ready,
  input  logic [NUM_CH*OFF_W-1:0]      ch_offset,
  input  logic [NUM_CH-1:0]            ch_latency,
  output logic [NUM_CH*WORD_WIDTH-1:0] out_left,
  output logic [NUM_CH*WORD_WIDTH-1:0] out_right,
  output logic [CNT_W-1:0]             out_index,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         cfg_err
);

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             n_q, n_d, n_base;
  logic [DEPTH*WORD_WIDTH-1:0]  win_q, win_d;
  logic [NUM_CH*WORD_WIDTH-1:0] left_q, left_d;
  logic [NUM_CH*WORD_WIDTH-1:0] right_q, right_d;
  logic [NUM_CH*WORD_WIDTH-1:0] tap_l, tap_r;
  logic [CNT_W-1:0]             idx_q, idx_d;
  logic                         valid_q, valid_d;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_tap
    round_tap #(
      .WORD_WIDTH(WORD_WIDTH),
      .DEPTH     (DEPTH),
      .WORD_COUNT(WORD_COUNT),
      .OFF_W     (OFF_W),
      .CNT_W     (CNT_W)
    ) u_tap (
      .n    (n_q),
      .d    (ch_offset[k*OFF_W +: OFF_W]),
      .l    (ch_latency[k]),
      .win  (win_q),
      .left (tap_l[k*WORD_WIDTH +: WORD_WIDTH]),
      .right(tap_r[k*WORD_WIDTH +: WORD_WIDTH])
    );
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    n_base  = n_q;
    win_d   = win_q;
    left_d  = left_q;
    right_d = right_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    unique case (state_q)
      ST_IDLE: begin
        // start clears the counter before a same-cycle word is counted
        if (start) n_base = '0;
        n_d = n_base;
        if (in_valid) begin
          win_d = {win_q[(DEPTH-1)*WORD_WIDTH-1:0], in_word};
          if (n_base != '1) n_d = n_base + CNT_W'(1);
          if (!in_only_add) state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        left_d  = tap_l;
        right_d = tap_r;
        idx_d   = n_q;
        valid_d = 1'b1;
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      win_q   <= '0;
      left_q  <= '0;
      right_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      win_q   <= win_d;
      left_q  <= left_d;
      right_q <= right_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

`ifdef ROUND_BLOCK_MC_CFG_CHECK_EN
  logic cfg_bad;
  logic err_q, err_d;

  always_comb begin
    cfg_bad = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (int'(ch_offset[k*OFF_W +: OFF_W]) + int'(ch_latency[k]) + 2 > DEPTH)
        cfg_bad = 1'b1;
    end
    err_d = err_q;
    if (state_q == ST_IDLE && start) err_d = 1'b0;
    if (state_q == ST_CALC && cfg_bad) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign cfg_err = err_q;
`else
  assign cfg_err = 1'b0;
`endif

  assign in_ready  = (state_q == ST_IDLE);
  assign out_left  = left_q;
  assign out_right = right_q;
  assign out_index = idx_q;
  assign out_valid = valid_q;

endmodule
